// File: rtl/dispatch_controller_if.sv
// Command, spike, network-control and sink signals between a dispatch
// controller (slave side) and its host/network/sink environment (master side).
interface dispatch_controller_if #(
  parameter int OPERAND_WIDTH = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_opcode;
  logic [OPERAND_WIDTH-1:0] cmd_operand;
  logic                     spk_valid;
  logic                     spk_ready;
  logic [OPERAND_WIDTH-1:0] spk_data;
  logic                     net_run;
  logic                     net_clear;
  logic                     sink_ready;
  logic                     sink_idle;
  logic [1:0]               flags;
  logic                     idle;

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, spk_ready, sink_ready, sink_idle,
    input  cmd_ready, spk_valid, spk_data, net_run, net_clear, flags, idle
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, spk_ready, sink_ready, sink_idle,
    output cmd_ready, spk_valid, spk_data, net_run, net_clear, flags, idle
  );
endinterface

// File: rtl/dispatch_controller.sv
// Dispatch controller: accepts RUN/SPK/SNC/CLR commands one at a time and
// sequences network run steps, spike injection, sink sync and network clear.
module dispatch_controller #(
  parameter int OPERAND_WIDTH = 16,
  parameter int CLR_CYCLES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dispatch_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SPK,
    S_SNC,
    S_CLR
  } state_t;

  localparam logic [1:0] OP_RUN = 2'd0;
  localparam logic [1:0] OP_SPK = 2'd1;
  localparam logic [1:0] OP_SNC = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  localparam logic [7:0]               CLR_LAST  = 8'(CLR_CYCLES - 1);
  localparam logic [OPERAND_WIDTH-1:0] COUNT_ONE = OPERAND_WIDTH'(1);

  state_t                   r_state;
  logic [OPERAND_WIDTH-1:0] r_operand;
  logic [OPERAND_WIDTH-1:0] r_count;
  logic [7:0]               r_clr_cnt;

  logic w_accept;
  logic w_net_run;

  assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_net_run     = (r_state == S_RUN) && bus.sink_ready;

  assign bus.net_run   = w_net_run;
  assign bus.spk_valid = (r_state == S_SPK);
  assign bus.spk_data  = r_operand;
  assign bus.net_clear = (r_state == S_CLR);
  assign bus.idle      = (r_state == S_IDLE);
  // CLR pulse marks the first clear cycle; SNC pulse marks the cycle the sink drains.
  assign bus.flags     = {(r_state == S_CLR) && (r_clr_cnt == 8'd0),
                          (r_state == S_SNC) && bus.sink_idle};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_operand <= '0;
      r_count   <= '0;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_operand <= bus.cmd_operand;
            case (bus.cmd_opcode)
              OP_RUN: begin
                // A zero-length RUN completes in place so the next command is not delayed.
                if (bus.cmd_operand != '0) begin
                  r_count <= bus.cmd_operand;
                  r_state <= S_RUN;
                end
              end
              OP_SPK: r_state <= S_SPK;
              OP_SNC: r_state <= S_SNC;
              OP_CLR: begin
                r_clr_cnt <= '0;
                r_state   <= S_CLR;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          if (w_net_run) begin
            r_count <= r_count - COUNT_ONE;
            if (r_count == COUNT_ONE) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_SPK: begin
          if (bus.spk_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_SNC: begin
          if (bus.sink_idle) begin
            r_state <= S_IDLE;
          end
        end
        S_CLR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dispatch_controller.md
DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 16: width of command operand, spike payload and run counter.
REQ-002 The block SHALL have parameter CLR_CYCLES, default 4: number of cycles net_clear is held per CLR; legal range 1..255.
REQ-003 Opcode encoding SHALL be RUN=0, SPK=1, SNC=2, CLR=3 on a 2-bit field, matching the shared dispatch opcode set.
REQ-004 Clocking SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: controller accepts a command.
REQ-009 The block SHALL have port cmd_opcode, input, 2 bits: dispatch opcode.
REQ-010 The block SHALL have port cmd_operand, input, OPERAND_WIDTH bits: RUN count or SPK payload; ignored for SNC and CLR.
REQ-011 The block SHALL have port spk_valid, output, 1 bit: spike offered to network input.
REQ-012 The block SHALL have port spk_ready, input, 1 bit: network accepts spike.
REQ-013 The block SHALL have port spk_data, output, OPERAND_WIDTH bits: spike payload.
REQ-014 The block SHALL have port net_run, output, 1 bit: advance the network one timestep this cycle.
REQ-015 The block SHALL have port net_clear, output, 1 bit: clear network state.
REQ-016 The block SHALL have port sink_ready, input, 1 bit: output sink can absorb one timestep of output.
REQ-017 The block SHALL have port sink_idle, input, 1 bit: output sink fully drained.
REQ-018 The block SHALL have port flags, output, 2 bits: stream flag pulses to sink; bit0=SNC, bit1=CLR.
REQ-019 The block SHALL have port idle, output, 1 bit: controller in IDLE with no work pending.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, SPK, SNC, CLR, and state SHALL be registered.
REQ-021 cmd_ready SHALL equal (state==IDLE) && !rst; a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-022 Accept in cycle T SHALL load the operand register and move to the opcode's state at edge T, so the action is visible in cycle T+1.
REQ-023 RUN with operand 0 SHALL be a no-op: the FSM stays in IDLE, and the next command is acceptable in T+1.
REQ-024 RUN with operand N>0 SHALL load a down-counter with N; net_run = (state==RUN) && sink_ready.
REQ-025 The counter SHALL decrement only on cycles where net_run=1; net_run SHALL be asserted in exactly N cycles total, and the FSM SHALL return to IDLE on the edge ending the Nth net_run cycle.
REQ-026 sink_ready=0 SHALL stall RUN with no net_run and no count change, for any duration.
REQ-027 Counter width SHALL be OPERAND_WIDTH; the maximum operand (all ones) SHALL yield 2^OPERAND_WIDTH-1 steps with no wrap.
REQ-028 In SPK, spk_valid=1 and spk_data=latched operand SHALL hold stable until spk_ready=1; the handshake cycle is the last SPK cycle, then IDLE.
REQ-029 spk_data SHALL be don't-care when spk_valid=0.
REQ-030 In SNC, the block SHALL wait while sink_idle=0; in the first cycle with sink_idle=1, flags[0]=1 for exactly that cycle, then IDLE. This is at least 1 cycle in SNC.
REQ-031 In CLR, net_clear=1 SHALL hold for exactly CLR_CYCLES consecutive cycles, flags[1]=1 in the first of them only, then IDLE; it SHALL not depend on sink inputs.
REQ-032 At most one of net_run, spk_valid, net_clear SHALL be 1 in any cycle.
REQ-033 flags SHALL be 0 outside the cycles defined above, and both bits SHALL never be 1 simultaneously.
REQ-034 idle SHALL equal (state==IDLE).
REQ-035 Commands arriving while not IDLE SHALL be held off by cmd_ready=0 and never dropped or reordered.

Reset
REQ-036 On a clock edge with rst=1: state SHALL go to IDLE, the counter to 0, the CLR timer to 0, and the operand register to 0.
REQ-037 In the cycle after reset: cmd_ready=1, idle=1, spk_valid=0, net_run=0, net_clear=0, flags=0.
REQ-038 Reset mid-operation SHALL abandon the command with no further outputs, no flag pulses and no spike completion; after rst deasserts, the next accepted command starts clean.
REQ-039 While rst=1, cmd_ready SHALL be 0, and no command SHALL be accepted.

Verification
REQ-040 Scenario RUN: RUN operand=5, sink_ready toggling 1,0,1,1,0,1,1 -> net_run in exactly 5 cycles, none when sink_ready=0, idle=1 after the 5th.
REQ-041 Scenario SPK: SPK operand=0x00A3, spk_ready low 3 cycles then high -> spk_valid high 4 cycles, spk_data=0x00A3 throughout, cmd_ready=1 the cycle after the handshake.
REQ-042 Scenario SNC: sink_idle=0 for 6 cycles, then 1 -> flags=01 for one cycle only when sink_idle first =1, then IDLE.
REQ-043 Scenario CLR: CLR with CLR_CYCLES=4 -> net_clear high exactly 4 cycles, flags=10 in the first only.
REQ-044 Scenario back-to-back: RUN 0, then RUN 2, SPK, CLR with cmd_valid held -> RUN 0 is accepted with no net_run, and the rest execute in order with outputs mutually exclusive.
REQ-045 Scenario reset: rst asserted in the 3rd cycle of RUN 10 -> no net_run after the reset edge, cmd_ready=1 and idle=1 the next cycle, and a following RUN 1 gives a single net_run.
